// File: rtl/gpio_irq_pkg.sv
// rtl/gpio_irq_pkg.sv - register map, defaults and address decode for gpio_irq_ctrl
package gpio_irq_pkg;

    localparam logic [31:0] DEF_BASE_ADDR  = 32'h4000_0010;

    localparam logic [31:0] OFS_IRQ_EN     = 32'h00;
    localparam logic [31:0] OFS_IRQ_TYPE   = 32'h04;
    localparam logic [31:0] OFS_IRQ_POL    = 32'h08;
    localparam logic [31:0] OFS_IRQ_STATUS = 32'h0C;
    localparam logic [31:0] OFS_SYNC_IN    = 32'h10;

    localparam logic [31:0] RST_REG        = 32'h0000_0000;
    localparam logic [31:0] RST_RDATA      = 32'h0000_0000;

    typedef enum logic [2:0] {
        REG_EN,
        REG_TYPE,
        REG_POL,
        REG_STATUS,
        REG_SYNC,
        REG_NONE
    } reg_sel_e;

    // Offsets below the base wrap to large values and fall into REG_NONE.
    function automatic reg_sel_e decode_reg(input logic [31:0] ofs);
        case (ofs)
            OFS_IRQ_EN:     return REG_EN;
            OFS_IRQ_TYPE:   return REG_TYPE;
            OFS_IRQ_POL:    return REG_POL;
            OFS_IRQ_STATUS: return REG_STATUS;
            OFS_SYNC_IN:    return REG_SYNC;
            default:        return REG_NONE;
        endcase
    endfunction

endpackage

// File: rtl/gpio_irq_ctrl_if.sv
// rtl/gpio_irq_ctrl_if.sv - single-cycle register bus between software master and gpio_irq_ctrl
interface gpio_irq_ctrl_if;

    logic        bus_wr_en;
    logic        bus_rd_en;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [31:0] bus_rdata;

    modport master (
        output bus_wr_en,
        output bus_rd_en,
        output bus_addr,
        output bus_wdata,
        input  bus_rdata
    );

    modport slave (
        input  bus_wr_en,
        input  bus_rd_en,
        input  bus_addr,
        input  bus_wdata,
        output bus_rdata
    );

endinterface

// File: rtl/gpio_sync_edge.sv
// rtl/gpio_sync_edge.sv - pad synchroniser chain, previous-value register and edge arming
module gpio_sync_edge #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] sync,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall
);

    localparam int unsigned ARM_MAX = SYNC_STAGES + 1;
    localparam int unsigned CW      = $clog2(ARM_MAX + 1);

    logic [WIDTH-1:0] r_chain [SYNC_STAGES];
    logic [WIDTH-1:0] r_prev;
    logic [CW-1:0]    r_arm_cnt;
    logic             w_armed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                r_chain[i] <= '0;
            end
            r_prev    <= '0;
            r_arm_cnt <= '0;
        end else begin
            r_chain[0] <= din;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                r_chain[i] <= r_chain[i-1];
            end
            r_prev <= r_chain[SYNC_STAGES-1];
            if (!w_armed) begin
                r_arm_cnt <= r_arm_cnt + CW'(1);
            end
        end
    end

    // Edges stay masked until the zero-reset chain has flushed pad levels through prev.
    assign w_armed = (r_arm_cnt == CW'(ARM_MAX));
    assign sync    = r_chain[SYNC_STAGES-1];
    assign rise    = w_armed ? (sync & ~r_prev) : '0;
    assign fall    = w_armed ? (~sync & r_prev) : '0;

endmodule

// File: rtl/gpio_irq_ctrl.sv
// rtl/gpio_irq_ctrl.sv - GPIO input conditioning, per-pin event latching and interrupt request
module gpio_irq_ctrl
    import gpio_irq_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic [31:0] BASE_ADDR   = DEF_BASE_ADDR
) (
    input  logic             clk,
    input  logic             rst_n,
    gpio_irq_ctrl_if.slave   bus,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_sync,
    output logic             irq
);

    logic [WIDTH-1:0] r_en;
    logic [WIDTH-1:0] r_type;
    logic [WIDTH-1:0] r_pol;
    logic [WIDTH-1:0] r_status;
    logic [31:0]      r_rdata;
    logic             r_irq;

    logic [WIDTH-1:0] w_sync;
    logic [WIDTH-1:0] w_rise;
    logic [WIDTH-1:0] w_fall;
    logic [WIDTH-1:0] w_event;
    logic [WIDTH-1:0] w_wdata;
    logic [WIDTH-1:0] w_clr;
    logic [31:0]      w_ofs;
    logic [31:0]      w_rd_val;
    reg_sel_e         w_sel;

    gpio_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk   (clk),
        .rst_n (rst_n),
        .din   (gpio_in),
        .sync  (w_sync),
        .rise  (w_rise),
        .fall  (w_fall)
    );

    assign w_ofs   = (bus.bus_addr & ~32'h3) - BASE_ADDR;
    assign w_sel   = decode_reg(w_ofs);
    assign w_wdata = bus.bus_wdata[WIDTH-1:0];
    assign w_clr   = (bus.bus_wr_en && (w_sel == REG_STATUS)) ? w_wdata : '0;

    assign w_event = (r_type & ((r_pol & w_rise) | (~r_pol & w_fall)))
                   | (~r_type & ~(w_sync ^ r_pol));

    always_comb begin
        w_rd_val = RST_RDATA;
        case (w_sel)
            REG_EN:     w_rd_val[WIDTH-1:0] = r_en;
            REG_TYPE:   w_rd_val[WIDTH-1:0] = r_type;
            REG_POL:    w_rd_val[WIDTH-1:0] = r_pol;
            REG_STATUS: w_rd_val[WIDTH-1:0] = r_status;
            REG_SYNC:   w_rd_val[WIDTH-1:0] = w_sync;
            default:    ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_en     <= RST_REG[WIDTH-1:0];
            r_type   <= RST_REG[WIDTH-1:0];
            r_pol    <= RST_REG[WIDTH-1:0];
            r_status <= RST_REG[WIDTH-1:0];
            r_rdata  <= RST_RDATA;
            r_irq    <= 1'b0;
        end else begin
            if (bus.bus_wr_en) begin
                case (w_sel)
                    REG_EN:   r_en   <= w_wdata;
                    REG_TYPE: r_type <= w_wdata;
                    REG_POL:  r_pol  <= w_wdata;
                    default:  ;
                endcase
            end
            // A fresh event overrides a same-cycle W1C on that bit.
            r_status <= (r_status & ~w_clr) | w_event;
            r_irq    <= |(r_status & r_en);
            if (bus.bus_rd_en) begin
                r_rdata <= w_rd_val;
            end
        end
    end

    assign bus.bus_rdata = r_rdata;
    assign gpio_sync     = w_sync;
    assign irq           = r_irq;

endmodule

// File: tb/tb_gpio_irq_ctrl.sv
// tb/tb_gpio_irq_ctrl.sv - scoreboard bench for gpio_irq_ctrl against a cycle-indexed reference model
module tb_gpio_irq_ctrl;
    import gpio_irq_pkg::*;

    localparam int          S    = 2;
    localparam logic [31:0] BASE = 32'h4000_0010;
    localparam logic [31:0] A_EN = BASE + 32'h00;
    localparam logic [31:0] A_TY = BASE + 32'h04;
    localparam logic [31:0] A_PO = BASE + 32'h08;
    localparam logic [31:0] A_ST = BASE + 32'h0C;
    localparam logic [31:0] A_SY = BASE + 32'h10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] gpio_in;
    logic [31:0] gpio_sync;
    logic        irq;

    gpio_irq_ctrl_if bus ();

    always #5 clk = ~clk;

    gpio_irq_ctrl #(
        .WIDTH       (32),
        .SYNC_STAGES (S),
        .BASE_ADDR   (BASE)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .gpio_in   (gpio_in),
        .gpio_sync (gpio_sync),
        .irq       (irq)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: samp[k] is gpio_in as sampled on the (k+1)-th edge since reset release.
    logic [31:0] samp[$];
    logic [31:0] rd_q[$];
    logic [31:0] m_en, m_type, m_pol, m_status, m_sync;
    logic [31:0] m_s1, m_s0, m_ev, m_clr, m_a;
    logic        m_irq;
    bit          rd_pend;
    int          m_n;

    function automatic logic [31:0] sync_at(input int k);
        if (k >= S) return samp[k-S];
        return 32'h0;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp.delete();
            rd_q.delete();
            rd_pend  = 0;
            m_en     = 0;
            m_type   = 0;
            m_pol    = 0;
            m_status = 0;
            m_sync   = 0;
            m_irq    = 0;
        end else begin
            samp.push_back(gpio_in);
            m_n  = samp.size();
            m_s1 = sync_at(m_n - 1);
            m_s0 = sync_at(m_n - 2);
            m_ev = 0;
            for (int i = 0; i < 32; i++) begin
                if (m_type[i]) begin
                    if (m_n >= S + 2)
                        m_ev[i] = m_pol[i] ? (m_s1[i] && !m_s0[i]) : (!m_s1[i] && m_s0[i]);
                end else begin
                    m_ev[i] = (m_s1[i] == m_pol[i]);
                end
            end
            m_a = bus.bus_addr & ~32'h3;
            if (bus.bus_rd_en) begin
                if      (m_a == A_EN) rd_q.push_back(m_en);
                else if (m_a == A_TY) rd_q.push_back(m_type);
                else if (m_a == A_PO) rd_q.push_back(m_pol);
                else if (m_a == A_ST) rd_q.push_back(m_status);
                else if (m_a == A_SY) rd_q.push_back(m_s1);
                else                  rd_q.push_back(32'h0);
                rd_pend = 1;
            end
            m_irq = |(m_status & m_en);
            m_clr = 0;
            if (bus.bus_wr_en) begin
                if      (m_a == A_EN) m_en   = bus.bus_wdata;
                else if (m_a == A_TY) m_type = bus.bus_wdata;
                else if (m_a == A_PO) m_pol  = bus.bus_wdata;
                else if (m_a == A_ST) m_clr  = bus.bus_wdata;
            end
            m_status = (m_status & ~m_clr) | m_ev;
            m_sync   = sync_at(m_n);
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            check("gpio_sync", gpio_sync, m_sync);
            check("irq", {31'h0, irq}, {31'h0, m_irq});
            if (rd_pend) begin
                rd_pend = 0;
                while (rd_q.size() > 0) check("rdata", bus.bus_rdata, rd_q.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus.bus_addr  = a;
        bus.bus_wdata = d;
        bus.bus_wr_en = 1'b1;
        tick();
        bus.bus_wr_en = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        bus.bus_addr  = a;
        bus.bus_rd_en = 1'b1;
        tick();
        bus.bus_rd_en = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        int sel;
        sel = int'($urandom_range(15));
        if (sel == 0) return BASE - 32'h4;
        if (sel == 1) return BASE + 32'h40;
        return BASE + 32'(4 * $urandom_range(5)) + 32'($urandom_range(3));
    endfunction

    initial begin
        gpio_in       = 32'hFFFF_FFFF;
        bus.bus_wr_en = 1'b0;
        bus.bus_rd_en = 1'b0;
        bus.bus_addr  = 32'h0;
        bus.bus_wdata = 32'h0;

        // 1: pins high through reset; edge mode from the second cycle, W1C the level residue
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        wr(A_TY, 32'hFFFF_FFFF);
        wr(A_PO, 32'hFFFF_FFFF);
        wr(A_ST, 32'hFFFF_FFFF);
        repeat (10) tick();
        rd(A_ST); check("t1_status", bus.bus_rdata, 32'h0);
        rd(A_SY); check("t1_sync_in", bus.bus_rdata, 32'hFFFF_FFFF);
        check("t1_irq", {31'h0, irq}, 32'h0);

        // 2: rising edge on pin 0
        wr(A_TY, 32'h1);
        wr(A_PO, 32'h1);
        wr(A_EN, 32'h1);
        gpio_in = 32'hFFFF_FFFE;
        repeat (5) tick();
        wr(A_ST, 32'hFFFF_FFFF);
        tick();
        gpio_in = 32'hFFFF_FFFF;
        repeat (3) tick();
        check("t2_irq_e2", {31'h0, irq}, 32'h0);
        tick();
        check("t2_irq_e3", {31'h0, irq}, 32'h1);
        rd(A_ST); check("t2_status", bus.bus_rdata, 32'h1);
        wr(A_ST, 32'h1);
        check("t2_irq_at_w", {31'h0, irq}, 32'h1);
        tick();
        check("t2_irq_w1", {31'h0, irq}, 32'h0);

        // 3: level-low on pin 4
        wr(A_EN, 32'h11);
        gpio_in = 32'hFFFF_FFEF;
        repeat (4) tick();
        rd(A_ST); check("t3_status_set", bus.bus_rdata, 32'h10);
        wr(A_ST, 32'h10);
        rd(A_ST); check("t3_status_held", bus.bus_rdata, 32'h10);
        check("t3_irq_held", {31'h0, irq}, 32'h1);
        gpio_in = 32'hFFFF_FFFF;
        repeat (4) tick();
        wr(A_ST, 32'h10);
        tick();
        rd(A_ST); check("t3_status_clr", bus.bus_rdata, 32'h0);
        check("t3_irq_clr", {31'h0, irq}, 32'h0);

        // 4: falling edge on pin 31, masked then enabled
        wr(A_TY, 32'h8000_0001);
        wr(A_PO, 32'h1);
        gpio_in = 32'h7FFF_FFFF;
        repeat (4) tick();
        rd(A_ST); check("t4_status", bus.bus_rdata, 32'h8000_0000);
        check("t4_irq_masked", {31'h0, irq}, 32'h0);
        wr(A_EN, 32'h8000_0011);
        check("t4_irq_at_w", {31'h0, irq}, 32'h0);
        tick();
        check("t4_irq_en", {31'h0, irq}, 32'h1);
        wr(A_ST, 32'hFFFF_FFFF);
        gpio_in = 32'hFFFF_FFFF;
        repeat (4) tick();

        // 5: W1C on the edge that latches a new rising event
        gpio_in = 32'hFFFF_FFFE;
        repeat (5) tick();
        wr(A_ST, 32'hFFFF_FFFF);
        tick();
        gpio_in = 32'hFFFF_FFFF;
        tick();
        tick();
        wr(A_ST, 32'h1);
        rd(A_ST); check("t5_event_wins", bus.bus_rdata, 32'h1);

        // simultaneous write and read
        bus.bus_addr  = A_EN;
        bus.bus_wdata = 32'h5;
        bus.bus_wr_en = 1'b1;
        bus.bus_rd_en = 1'b1;
        tick();
        bus.bus_wr_en = 1'b0;
        bus.bus_rd_en = 1'b0;
        check("wr_rd_old", bus.bus_rdata, 32'h8000_0011);
        rd(A_EN); check("wr_rd_new", bus.bus_rdata, 32'h5);

        // 6: unmapped reads, ignored writes
        rd(A_SY); check("t6_sync_pre", bus.bus_rdata, 32'hFFFF_FFFF);
        rd(BASE + 32'h14); check("t6_unmapped", bus.bus_rdata, 32'h0);
        rd(A_SY);
        rd(BASE - 32'h4); check("t6_below", bus.bus_rdata, 32'h0);
        wr(A_SY, 32'h1234);
        wr(BASE + 32'h14, 32'hFFFF_FFFF);
        rd(A_SY); check("t6_sync_ro", bus.bus_rdata, 32'hFFFF_FFFF);
        rd(A_EN); check("t6_en_kept", bus.bus_rdata, 32'h5);
        check("t6_irq_pending", {31'h0, irq}, 32'h1);

        // asynchronous reset mid-event
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_rdata", bus.bus_rdata, 32'h0);
        check("rst_sync", gpio_sync, 32'h0);
        check("rst_irq", {31'h0, irq}, 32'h0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // randomized traffic against the model
        for (int c = 0; c < 3000; c++) begin
            int r;
            if ($urandom_range(3) == 0) gpio_in = gpio_in ^ (32'h1 << $urandom_range(31));
            r = int'($urandom_range(9));
            bus.bus_addr  = rand_addr();
            bus.bus_wdata = $urandom;
            bus.bus_wr_en = (r < 3) || (r == 9);
            bus.bus_rd_en = ((r >= 3) && (r < 7)) || (r == 9);
            tick();
        end
        bus.bus_wr_en = 1'b0;
        bus.bus_rd_en = 1'b0;
        repeat (3) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
